// File: rtl/chip8_sound_delay_timers.sv
// rtl/chip8_sound_delay_timers.sv - CHIP-8 delay/sound timers with buzzer drive
// Optional square-wave tone generator enabled by CHIP8_BUZZER_TONE_EN.
module chip8_sound_delay_timers #(
  parameter int unsigned TONE_DIV = 56818,
  parameter int          TIMER_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_60hz,
  input  logic               freeze,
  input  logic               dt_we,
  input  logic               st_we,
  input  logic [TIMER_W-1:0] wr_data,
  output logic [TIMER_W-1:0] dt_value,
  output logic [TIMER_W-1:0] st_value,
  output logic               dt_zero,
  output logic               sound_active,
  output logic               buzzer
);

  logic dec_en;

  assign dec_en       = tick_60hz & ~freeze;
  assign dt_zero      = (dt_value == '0);
  assign sound_active = (st_value != '0);

  // A write in the same cycle as a tick wins; the tick is dropped for that timer only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dt_value <= '0;
    end else if (dt_we) begin
      dt_value <= wr_data;
    end else if (dec_en && !dt_zero) begin
      dt_value <= dt_value - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_value <= '0;
    end else if (st_we) begin
      st_value <= wr_data;
    end else if (dec_en && sound_active) begin
      st_value <= st_value - TIMER_W'(1);
    end
  end

`ifdef CHIP8_BUZZER_TONE_EN
  logic [31:0] phase;
  logic        tone;

  // Phase runs only while sounding, so an ST reload mid-tone keeps the waveform continuous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      tone  <= 1'b0;
    end else if (!sound_active) begin
      phase <= '0;
      tone  <= 1'b0;
    end else if (phase == TONE_DIV - 1) begin
      phase <= '0;
      tone  <= ~tone;
    end else begin
      phase <= phase + 32'd1;
    end
  end

  assign buzzer = tone;
`else
  assign buzzer = sound_active;
`endif

endmodule

// File: tb/tb_chip8_sound_delay_timers.sv
// tb/tb_chip8_sound_delay_timers.sv - randomized model-checked bench for chip8_sound_delay_timers
module tb_chip8_sound_delay_timers;
  localparam int W   = 8;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick_60hz = 1'b0;
  logic         freeze = 1'b0;
  logic         dt_we = 1'b0;
  logic         st_we = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] dt_value;
  logic [W-1:0] st_value;
  logic         dt_zero;
  logic         sound_active;
  logic         buzzer;

  int     checks = 0;
  int     errors = 0;
  int     m_dt = 0;
  int     m_st = 0;
  longint m_n = 0;

  chip8_sound_delay_timers #(.TONE_DIV(DIV), .TIMER_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .tick_60hz(tick_60hz), .freeze(freeze),
    .dt_we(dt_we), .st_we(st_we), .wr_data(wr_data),
    .dt_value(dt_value), .st_value(st_value), .dt_zero(dt_zero),
    .sound_active(sound_active), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  // Reference: buzzer parity follows how many edges have elapsed since sounding started.
  function automatic logic exp_buzzer();
`ifdef CHIP8_BUZZER_TONE_EN
    return ((m_n / DIV) % 2) == 1;
`else
    return m_st != 0;
`endif
  endfunction

  task automatic drive(input logic dwe, input logic swe, input logic tk, input logic frz,
                       input logic [W-1:0] d);
    bit sounding;
    dt_we = dwe; st_we = swe; tick_60hz = tk; freeze = frz; wr_data = d;
    @(posedge clk);
    sounding = (m_st != 0);
    if (dwe) m_dt = d;
    else if (tk && !frz && m_dt > 0) m_dt = m_dt - 1;
    if (swe) m_st = d;
    else if (tk && !frz && m_st > 0) m_st = m_st - 1;
    m_n = sounding ? m_n + 1 : 0;
    #1;
    dt_we = 1'b0; st_we = 1'b0; tick_60hz = 1'b0; freeze = 1'b0;
  endtask

  task automatic model_reset();
    m_dt = 0; m_st = 0; m_n = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    checks++; if (dt_value !== 8'd0) begin errors++; $display("FAIL reset_dt got %0d want 0", dt_value); end
    checks++; if (st_value !== 8'd0) begin errors++; $display("FAIL reset_st got %0d want 0", st_value); end
    checks++; if (dt_zero !== 1'b1) begin errors++; $display("FAIL reset_dt_zero got %b want 1", dt_zero); end
    checks++; if (sound_active !== 1'b0) begin errors++; $display("FAIL reset_sound got %b want 0", sound_active); end
    checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer got %b want 0", buzzer); end
  endtask

  task automatic test_dt_countdown();
    drive(1, 0, 0, 0, 8'd3);
    checks++; if (dt_value !== 8'd3) begin errors++; $display("FAIL dt_load got %0d want 3", dt_value); end
    for (int k = 1; k <= 4; k++) begin
      repeat (9) drive(0, 0, 0, 0, 8'd0);
      checks++; if (dt_zero !== (k > 3)) begin errors++; $display("FAIL dt_zero_pre tick %0d got %b want %b", k, dt_zero, k > 3); end
      drive(0, 0, 1, 0, 8'd0);
      checks++; if (dt_value !== W'((k >= 3) ? 0 : 3 - k)) begin errors++; $display("FAIL dt_count tick %0d got %0d want %0d", k, dt_value, (k >= 3) ? 0 : 3 - k); end
      checks++; if (dt_zero !== (k >= 3)) begin errors++; $display("FAIL dt_zero tick %0d got %b want %b", k, dt_zero, k >= 3); end
    end
  endtask

  task automatic test_collision();
    drive(1, 1, 0, 0, 8'd5);
    drive(1, 0, 1, 0, 8'd9);
    checks++; if (dt_value !== 8'd9) begin errors++; $display("FAIL coll_dt got %0d want 9", dt_value); end
    checks++; if (st_value !== 8'd4) begin errors++; $display("FAIL coll_st got %0d want 4", st_value); end
    drive(0, 1, 1, 0, 8'd7);
    checks++; if (dt_value !== 8'd8 || st_value !== 8'd7) begin errors++; $display("FAIL coll_st_wins got %0d/%0d want 8/7", dt_value, st_value); end
    drive(1, 1, 1, 0, 8'h20);
    checks++; if (dt_value !== 8'h20 || st_value !== 8'h20) begin errors++; $display("FAIL both_we got %0h/%0h want 20/20", dt_value, st_value); end
    drive(0, 1, 0, 0, 8'd0);
    checks++; if (sound_active !== 1'b0) begin errors++; $display("FAIL st_write0 got %b want 0", sound_active); end
  endtask

  task automatic test_freeze();
    drive(1, 0, 0, 0, 8'd2);
    repeat (5) drive(0, 0, 1, 1, 8'd0);
    checks++; if (dt_value !== 8'd2) begin errors++; $display("FAIL freeze_hold got %0d want 2", dt_value); end
    drive(0, 0, 1, 0, 8'd0);
    checks++; if (dt_value !== 8'd1) begin errors++; $display("FAIL freeze_release got %0d want 1", dt_value); end
  endtask

  task automatic test_sound();
    drive(1, 1, 0, 0, 8'd0);
    drive(0, 1, 0, 0, 8'd2);
    checks++; if (sound_active !== 1'b1) begin errors++; $display("FAIL sound_on got %b want 1", sound_active); end
    for (int c = 0; c < 20; c++) begin
      drive(0, 0, (c == 9 || c == 17), 0, 8'd0);
      checks++; if (buzzer !== exp_buzzer()) begin errors++; $display("FAIL buzzer cyc %0d got %b want %b", c, buzzer, exp_buzzer()); end
    end
    checks++; if (st_value !== 8'd0 || sound_active !== 1'b0) begin errors++; $display("FAIL sound_off got st=%0d act=%b want 0/0", st_value, sound_active); end
    drive(0, 0, 0, 0, 8'd0);
    checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL buzzer_off got %b want 0", buzzer); end
    repeat (3) drive(0, 0, 1, 0, 8'd0);
    checks++; if (st_value !== 8'd0 || dt_value !== 8'd0) begin errors++; $display("FAIL no_wrap got %0d/%0d want 0/0", dt_value, st_value); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic dwe, swe, tk, frz;
      logic [W-1:0] d;
      dwe = ($urandom_range(0, 9) == 0);
      swe = ($urandom_range(0, 9) == 0);
      tk  = ($urandom_range(0, 2) == 0);
      frz = ($urandom_range(0, 3) == 0);
      d   = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      drive(dwe, swe, tk, frz, d);
      checks++;
      if (dt_value !== W'(m_dt) || st_value !== W'(m_st) || dt_zero !== (m_dt == 0) ||
          sound_active !== (m_st != 0) || buzzer !== exp_buzzer()) begin
        errors++;
        $display("FAIL random cyc %0d got dt=%0d st=%0d z=%b s=%b bz=%b want dt=%0d st=%0d z=%b s=%b bz=%b",
                 c, dt_value, st_value, dt_zero, sound_active, buzzer,
                 m_dt, m_st, m_dt == 0, m_st != 0, exp_buzzer());
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 0, 0, 8'd9);
    dt_we = 1'b1; st_we = 1'b1; wr_data = 8'd33; tick_60hz = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dt_value !== 8'd0 || st_value !== 8'd0 || buzzer !== 1'b0) begin errors++; $display("FAIL async_reset got %0d/%0d/%b want 0/0/0", dt_value, st_value, buzzer); end
    @(posedge clk); #1;
    checks++; if (dt_value !== 8'd0 || st_value !== 8'd0) begin errors++; $display("FAIL reset_drops_write got %0d/%0d want 0/0", dt_value, st_value); end
    dt_we = 1'b0; st_we = 1'b0; tick_60hz = 1'b0;
    rst_n = 1'b1;
    model_reset();
    drive(1, 0, 0, 0, 8'd4);
    checks++; if (dt_value !== 8'd4 || dt_zero !== 1'b0) begin errors++; $display("FAIL post_reset_load got %0d/%b want 4/0", dt_value, dt_zero); end
  endtask

  initial begin
    test_reset();
    test_dt_countdown();
    test_collision();
    test_freeze();
    test_sound();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
